// File: rtl/drive_mask_sequencer.sv
// Drive-mask sequencer: queues gate commands in a small FIFO and emits per-bank instruction beats.
// Define DRIVE_MASK_SEQ_ZCORR_EN to add the Z-correction beat after every gate beat.
module drive_mask_sequencer #(
    parameter int NUM_GROUP          = 2,
    parameter int NUM_BANK_PER_GROUP = 4,
    parameter int NUM_QUBIT_PER_BANK = 4,
    parameter int START_TIME_WIDTH   = 16,
    parameter int PHASE_WIDTH        = 10,
    parameter int NUM_PHASE          = 8,
    parameter int FIFO_DEPTH         = 4,
    parameter logic [PHASE_WIDTH-1:0] Y_INST = 10'h100,
    localparam int NUM_BANK  = NUM_GROUP * NUM_BANK_PER_GROUP,
    localparam int NUM_QUBIT = NUM_BANK * NUM_QUBIT_PER_BANK,
    localparam int SEL_WIDTH = (NUM_PHASE > 1) ? $clog2(NUM_PHASE) : 1,
    localparam int IW        = START_TIME_WIDTH + PHASE_WIDTH + 1 + NUM_QUBIT_PER_BANK,
    localparam int CNT_WIDTH = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [START_TIME_WIDTH-1:0]      start_time_in,
    input  logic [SEL_WIDTH-1:0]             bs_select_in,
    input  logic [NUM_QUBIT-1:0]             mask_in,
    input  logic [NUM_PHASE*PHASE_WIDTH-1:0] phase_table_in,
    input  logic                             out_stall,
    output logic [NUM_BANK*IW-1:0]           inst_out,
    output logic [NUM_BANK-1:0]              inst_wr_en_out,
    output logic                             busy,
    output logic [CNT_WIDTH-1:0]             fifo_count
);
    localparam int PTR_WIDTH   = $clog2(FIFO_DEPTH);
    localparam int ENTRY_WIDTH = START_TIME_WIDTH + SEL_WIDTH + NUM_QUBIT;

`ifdef DRIVE_MASK_SEQ_ZCORR_EN
    typedef enum logic [1:0] {IDLE = 2'd0, GATE = 2'd1, ZCORR = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, GATE = 2'd1} state_t;
`endif

    state_t state_reg, state_next;

    // ---------------- command FIFO ----------------
    logic [ENTRY_WIDTH-1:0]      fifo_mem [FIFO_DEPTH];
    logic [PTR_WIDTH-1:0]        wr_ptr_reg;
    logic [PTR_WIDTH-1:0]        rd_ptr_reg;
    logic [CNT_WIDTH-1:0]        count_reg;
    logic                        push;
    logic                        pop;
    logic                        fifo_nonempty;
    logic [START_TIME_WIDTH-1:0] head_time;
    logic [SEL_WIDTH-1:0]        head_sel;
    logic [NUM_QUBIT-1:0]        head_mask;
    logic [PHASE_WIDTH-1:0]      head_phase;

    // Readiness depends only on the registered count, so a same-cycle pop never frees a slot early.
    assign in_ready      = (count_reg != CNT_WIDTH'(FIFO_DEPTH));
    assign fifo_nonempty = (count_reg != '0);
    assign push          = in_valid && in_ready;
    assign {head_time, head_sel, head_mask} = fifo_mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= {start_time_in, bs_select_in, mask_in};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_WIDTH'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_WIDTH'(1);
            if (push && !pop) begin
                count_reg <= count_reg + CNT_WIDTH'(1);
            end else if (!push && pop) begin
                count_reg <= count_reg - CNT_WIDTH'(1);
            end
        end
    end

    // ---------------- phase table lookup ----------------
    logic [PHASE_WIDTH-1:0] phase_entry [NUM_PHASE];

    generate
        for (genvar gi = 0; gi < NUM_PHASE; gi++) begin : g_phase
            assign phase_entry[gi] = phase_table_in[gi*PHASE_WIDTH +: PHASE_WIDTH];
        end
    endgenerate

    assign head_phase = (int'(head_sel) < NUM_PHASE) ? phase_entry[head_sel] : phase_entry[0];

    // ---------------- beat construction ----------------
    logic [NUM_BANK*IW-1:0] inst_reg, inst_next, gate_inst;
    logic [NUM_BANK-1:0]    wr_en_reg, wr_en_next, gate_wr;
`ifdef DRIVE_MASK_SEQ_ZCORR_EN
    logic [NUM_BANK*IW-1:0] zcorr_inst;
`endif

    generate
        for (genvar gi = 0; gi < NUM_BANK; gi++) begin : g_bank
            logic [NUM_QUBIT_PER_BANK-1:0] bank_mask;
            assign bank_mask            = head_mask[gi*NUM_QUBIT_PER_BANK +: NUM_QUBIT_PER_BANK];
            assign gate_inst[gi*IW +: IW] = {head_time, head_phase, 1'b0, bank_mask};
            assign gate_wr[gi]          = |bank_mask;
`ifdef DRIVE_MASK_SEQ_ZCORR_EN
            // The Z-correction beat reuses the time and mask already sitting in the output register.
            assign zcorr_inst[gi*IW +: IW] = {inst_reg[gi*IW + IW - 1 -: START_TIME_WIDTH], Y_INST, 1'b1,
                                              inst_reg[gi*IW +: NUM_QUBIT_PER_BANK]};
`endif
        end
    endgenerate

    // ---------------- FSM ----------------
    logic advance;

    always_comb begin
        state_next = state_reg;
        inst_next  = inst_reg;
        wr_en_next = wr_en_reg;
        pop        = 1'b0;
        advance    = 1'b0;
        case (state_reg)
            IDLE:    advance = fifo_nonempty;
`ifdef DRIVE_MASK_SEQ_ZCORR_EN
            GATE: begin
                if (!out_stall) begin
                    state_next = ZCORR;
                    inst_next  = zcorr_inst;
                end
            end
            ZCORR:   advance = !out_stall;
`else
            GATE:    advance = !out_stall;
`endif
            default: state_next = IDLE;
        endcase
        if (advance) begin
            if (fifo_nonempty) begin
                pop        = 1'b1;
                state_next = GATE;
                inst_next  = gate_inst;
                wr_en_next = gate_wr;
            end else begin
                state_next = IDLE;
                inst_next  = '0;
                wr_en_next = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            inst_reg  <= '0;
            wr_en_reg <= '0;
        end else begin
            state_reg <= state_next;
            inst_reg  <= inst_next;
            wr_en_reg <= wr_en_next;
        end
    end

    assign inst_out       = inst_reg;
    assign inst_wr_en_out = wr_en_reg;
    assign fifo_count     = count_reg;
    assign busy           = (state_reg != IDLE) || fifo_nonempty;

endmodule

// File: tb/tb_drive_mask_sequencer.sv
// Randomized bench for drive_mask_sequencer: a queue-based command model predicts every output each cycle.
module tb_drive_mask_sequencer;
    localparam int NB    = 8;
    localparam int QB    = 4;
    localparam int NQ    = NB * QB;
    localparam int TW    = 16;
    localparam int PW    = 10;
    localparam int NPH   = 8;
    localparam int SW    = 3;
    localparam int DEPTH = 4;
    localparam int IW    = TW + PW + 1 + QB;
    localparam logic [PW-1:0] Y_INST = 10'h100;
`ifdef DRIVE_MASK_SEQ_ZCORR_EN
    localparam int BEATS = 2;
`else
    localparam int BEATS = 1;
`endif

    typedef struct {
        logic [TW-1:0] t;
        logic [SW-1:0] sel;
        logic [NQ-1:0] mask;
    } cmd_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [TW-1:0]     start_time_in;
    logic [SW-1:0]     bs_select_in;
    logic [NQ-1:0]     mask_in;
    logic [NPH*PW-1:0] phase_table_in;
    logic              out_stall;
    logic [NB*IW-1:0]  inst_out;
    logic [NB-1:0]     inst_wr_en_out;
    logic              busy;
    logic [2:0]        fifo_count;

    drive_mask_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .start_time_in (start_time_in),
        .bs_select_in  (bs_select_in),
        .mask_in       (mask_in),
        .phase_table_in(phase_table_in),
        .out_stall     (out_stall),
        .inst_out      (inst_out),
        .inst_wr_en_out(inst_wr_en_out),
        .busy          (busy),
        .fifo_count    (fifo_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: pending commands, the command on the outputs and which beat it is on.
    cmd_t          q[$];
    cmd_t          cur;
    logic [PW-1:0] cur_phase;
    bit            active = 1'b0;
    int            beat = 0;
    bit            rand_table = 1'b0;
    logic [NB*IW-1:0] exp_inst;
    logic [NB-1:0]    exp_wr;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [PW-1:0] lookup(input logic [SW-1:0] sel);
        int k;
        k = (int'(sel) < NPH) ? int'(sel) : 0;
        return phase_table_in[k*PW +: PW];
    endfunction

    function automatic cmd_t rand_cmd();
        cmd_t c;
        int   kind;
        c.t   = TW'($urandom);
        c.sel = SW'($urandom);
        kind  = $urandom_range(0, 7);
        if (kind == 0)      c.mask = '0;
        else if (kind == 1) c.mask = NQ'(32'hF) << (QB * $urandom_range(0, NB - 1));
        else                c.mask = NQ'($urandom);
        return c;
    endfunction

    task automatic compare_all(input string tag);
        check({tag, "_inst"},  512'(inst_out),       512'(exp_inst));
        check({tag, "_wr"},    512'(inst_wr_en_out), 512'(exp_wr));
        check({tag, "_cnt"},   512'(fifo_count),     512'(q.size()));
        check({tag, "_ready"}, 512'(in_ready),       512'(q.size() < DEPTH));
        check({tag, "_busy"},  512'(busy),           512'(active || (q.size() != 0)));
    endtask

    // One clock: drive inputs, advance the model across the edge, then compare.
    task automatic step(input string tag, input logic v, input cmd_t c, input logic s);
        bit accepted;
        logic [QB-1:0] bm;
        @(negedge clk);
        in_valid      = v;
        start_time_in = c.t;
        bs_select_in  = c.sel;
        mask_in       = c.mask;
        out_stall     = s;
        if (rand_table) begin
            for (int k = 0; k < NPH; k++) phase_table_in[k*PW +: PW] = PW'($urandom);
        end
        accepted = v && (q.size() < DEPTH);
        if (!active || !s) begin
            if (active && (beat + 1 < BEATS)) begin
                beat++;
            end else if (q.size() > 0) begin
                cur       = q.pop_front();
                cur_phase = lookup(cur.sel);
                beat      = 0;
                active    = 1'b1;
            end else begin
                active = 1'b0;
            end
        end
        if (accepted) begin
            q.push_back(c);
            $display("push t=%h sel=%0d mask=%h (queued %0d)", c.t, c.sel, c.mask, q.size());
        end
        exp_inst = '0;
        exp_wr   = '0;
        if (active) begin
            for (int b = 0; b < NB; b++) begin
                bm = cur.mask[b*QB +: QB];
                exp_inst[b*IW +: IW] = {cur.t, (beat == 0) ? cur_phase : Y_INST, 1'(beat == 1), bm};
                exp_wr[b] = |bm;
            end
        end
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    task automatic idle_steps(input string tag, input int n);
        cmd_t z;
        z = '{t: '0, sel: '0, mask: '0};
        for (int i = 0; i < n; i++) step(tag, 1'b0, z, 1'b0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        #2;
        rst      = 1'b1;
        in_valid = 1'b0;
        #1;
        q.delete();
        active = 1'b0;
        beat   = 0;
        check("rst_inst",  512'(inst_out),       512'(0));
        check("rst_wr",    512'(inst_wr_en_out), 512'(0));
        check("rst_cnt",   512'(fifo_count),     512'(0));
        check("rst_busy",  512'(busy),           512'(0));
        check("rst_ready", 512'(in_ready),       512'(1));
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        cmd_t c;
        rst            = 1'b1;
        in_valid       = 1'b0;
        start_time_in  = '0;
        bs_select_in   = '0;
        mask_in        = '0;
        out_stall      = 1'b0;
        phase_table_in = '0;
        @(posedge clk);
        #1;
        check("init_inst",  512'(inst_out),       512'(0));
        check("init_wr",    512'(inst_wr_en_out), 512'(0));
        check("init_cnt",   512'(fifo_count),     512'(0));
        check("init_ready", 512'(in_ready),       512'(1));
        check("init_busy",  512'(busy),           512'(0));
        @(negedge clk);
        rst = 1'b0;

        // Single command through the table, with fixed entry 3.
        for (int k = 0; k < NPH; k++) phase_table_in[k*PW +: PW] = PW'($urandom);
        phase_table_in[3*PW +: PW] = 10'h0C0;
        c = '{t: 16'h0010, sel: 3'd3, mask: 32'h0000_000F};
        step("basic", 1'b1, c, 1'b0);
        idle_steps("basic", 1);
        check("basic_wr0",    512'(inst_wr_en_out),      512'(8'h01));
        check("basic_phase0", 512'(inst_out[QB+1 +: PW]), 512'(10'h0C0));
        check("basic_mode0",  512'(inst_out[QB]),         512'(0));
        idle_steps("basic", 1);
`ifdef DRIVE_MASK_SEQ_ZCORR_EN
        check("basic_phase1", 512'(inst_out[QB+1 +: PW]), 512'(10'h100));
        check("basic_mode1",  512'(inst_out[QB]),         512'(1));
`else
        check("basic_wr1",    512'(inst_wr_en_out),       512'(0));
`endif
        idle_steps("basic", 3);

        // Outer banks only.
        c = '{t: 16'h1234, sel: 3'd5, mask: 32'h8000_0001};
        step("edge", 1'b1, c, 1'b0);
        idle_steps("edge", 1);
        check("edge_wr",    512'(inst_wr_en_out),     512'(8'h81));
        check("edge_bank7", 512'(inst_out[7*IW +: QB]), 512'(4'b1000));
        check("edge_bank0", 512'(inst_out[0 +: QB]),    512'(4'b0001));
        idle_steps("edge", 3);

        // Fill under stall, then release: queue tops out at DEPTH and drains without gaps.
        for (int i = 0; i < 6; i++) begin
            c = rand_cmd();
            c.mask[0] = 1'b1;
            step("fill", 1'b1, c, 1'b1);
        end
        check("fill_ready", 512'(in_ready),   512'(0));
        check("fill_cnt",   512'(fifo_count), 512'(4));
        idle_steps("drain", 5 * BEATS + 3);

        // Stall held for three cycles during the gate beat.
        c = rand_cmd();
        step("hold", 1'b1, c, 1'b0);
        idle_steps("hold", 1);
        for (int i = 0; i < 3; i++) step("hold", 1'b0, c, 1'b1);
        idle_steps("hold", 3);

        // Reset with an active command and two queued behind it.
        for (int i = 0; i < 3; i++) step("midrst", 1'b1, rand_cmd(), 1'b0);
        apply_reset();
        idle_steps("postrst", 4);

        // Random traffic with a changing phase table.
        rand_table = 1'b1;
        for (int i = 0; i < 400; i++) begin
            c = rand_cmd();
            step("rand", 1'($urandom_range(0, 99) < 60), c, 1'($urandom_range(0, 99) < 25));
            if (i == 250) apply_reset();
        end
        idle_steps("final", 12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
